// File: rtl/holy_axi_lite_demux.sv
// 1-to-N AXI-Lite router: decodes each address against a base/mask map and
// forwards to one slave; unmapped addresses complete locally with DECERR.
module holy_axi_lite_demux #(
  parameter int N_SLAVES = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int STRB_W   = DATA_W / 8,
  parameter logic [N_SLAVES*ADDR_W-1:0] BASE_ADDRS = {32'h2000_0000, 32'h1000_0000},
  parameter logic [N_SLAVES*ADDR_W-1:0] ADDR_MASKS = {32'hF000_0000, 32'hF000_0000}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            s_axi_lite_awaddr,
  input  logic                         s_axi_lite_awvalid,
  output logic                         s_axi_lite_awready,
  input  logic [DATA_W-1:0]            s_axi_lite_wdata,
  input  logic [STRB_W-1:0]            s_axi_lite_wstrb,
  input  logic                         s_axi_lite_wvalid,
  output logic                         s_axi_lite_wready,
  output logic [1:0]                   s_axi_lite_bresp,
  output logic                         s_axi_lite_bvalid,
  input  logic                         s_axi_lite_bready,
  input  logic [ADDR_W-1:0]            s_axi_lite_araddr,
  input  logic                         s_axi_lite_arvalid,
  output logic                         s_axi_lite_arready,
  output logic [DATA_W-1:0]            s_axi_lite_rdata,
  output logic [1:0]                   s_axi_lite_rresp,
  output logic                         s_axi_lite_rvalid,
  input  logic                         s_axi_lite_rready,
  output logic [N_SLAVES*ADDR_W-1:0]   m_axi_lite_awaddr,
  output logic [N_SLAVES-1:0]          m_axi_lite_awvalid,
  input  logic [N_SLAVES-1:0]          m_axi_lite_awready,
  output logic [N_SLAVES*DATA_W-1:0]   m_axi_lite_wdata,
  output logic [N_SLAVES*STRB_W-1:0]   m_axi_lite_wstrb,
  output logic [N_SLAVES-1:0]          m_axi_lite_wvalid,
  input  logic [N_SLAVES-1:0]          m_axi_lite_wready,
  input  logic [N_SLAVES*2-1:0]        m_axi_lite_bresp,
  input  logic [N_SLAVES-1:0]          m_axi_lite_bvalid,
  output logic [N_SLAVES-1:0]          m_axi_lite_bready,
  output logic [N_SLAVES*ADDR_W-1:0]   m_axi_lite_araddr,
  output logic [N_SLAVES-1:0]          m_axi_lite_arvalid,
  input  logic [N_SLAVES-1:0]          m_axi_lite_arready,
  input  logic [N_SLAVES*DATA_W-1:0]   m_axi_lite_rdata,
  input  logic [N_SLAVES*2-1:0]        m_axi_lite_rresp,
  input  logic [N_SLAVES-1:0]          m_axi_lite_rvalid,
  output logic [N_SLAVES-1:0]          m_axi_lite_rready
);

  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic [2:0] {W_IDLE, W_FWD, W_WAITB, W_RESP, W_ERR} w_state_t;
  typedef enum logic [2:0] {R_IDLE, R_FWD, R_WAITR, R_RESP, R_ERR} r_state_t;

  // Result is {hit, sel}; scanning downwards lets the lowest matching index win.
  function automatic logic [SEL_W:0] f_decode(input logic [ADDR_W-1:0] addr);
    logic [SEL_W:0] res;
    res = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr & ADDR_MASKS[i*ADDR_W +: ADDR_W]) ==
          (BASE_ADDRS[i*ADDR_W +: ADDR_W] & ADDR_MASKS[i*ADDR_W +: ADDR_W]))
        res = {1'b1, SEL_W'(i)};
    end
    return res;
  endfunction

  function automatic logic [N_SLAVES-1:0] f_onehot(input logic [SEL_W-1:0] sel);
    logic [N_SLAVES-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel == SEL_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  w_state_t            r_wstate;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_aw_held, r_w_held, r_awready, r_wready;
  logic [SEL_W-1:0]    r_wsel;
  logic [N_SLAVES-1:0] r_m_awvalid, r_m_wvalid, r_m_bready;
  logic                r_bvalid;
  logic [1:0]          r_bresp;

  r_state_t            r_rstate;
  logic [ADDR_W-1:0]   r_araddr;
  logic                r_ar_held, r_arready;
  logic [SEL_W-1:0]    r_rsel;
  logic [N_SLAVES-1:0] r_m_arvalid, r_m_rready;
  logic                r_rvalid;
  logic [1:0]          r_rresp;
  logic [DATA_W-1:0]   r_rdata;

  logic [SEL_W:0]      w_wdec, w_rdec;
  logic                w_whit, w_rhit;
  logic [SEL_W-1:0]    w_wsel, w_rsel;
  logic [N_SLAVES-1:0] w_awv_nxt, w_wv_nxt, w_arv_nxt;
  logic [1:0]          w_bresp_sel, w_rresp_sel;
  logic [DATA_W-1:0]   w_rdata_sel;

  assign w_wdec    = f_decode(r_awaddr);
  assign w_whit    = w_wdec[SEL_W];
  assign w_wsel    = w_wdec[SEL_W-1:0];
  assign w_rdec    = f_decode(r_araddr);
  assign w_rhit    = w_rdec[SEL_W];
  assign w_rsel    = w_rdec[SEL_W-1:0];
  assign w_awv_nxt = r_m_awvalid & ~m_axi_lite_awready;
  assign w_wv_nxt  = r_m_wvalid & ~m_axi_lite_wready;
  assign w_arv_nxt = r_m_arvalid & ~m_axi_lite_arready;

  always_comb begin
    w_bresp_sel = '0;
    w_rresp_sel = '0;
    w_rdata_sel = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (r_wsel == SEL_W'(i)) w_bresp_sel = m_axi_lite_bresp[i*2 +: 2];
      if (r_rsel == SEL_W'(i)) begin
        w_rresp_sel = m_axi_lite_rresp[i*2 +: 2];
        w_rdata_sel = m_axi_lite_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Write path: AW and W are captured independently, then forwarded together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate    <= W_IDLE;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_aw_held   <= 1'b0;
      r_w_held    <= 1'b0;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_wsel      <= '0;
      r_m_awvalid <= '0;
      r_m_wvalid  <= '0;
      r_m_bready  <= '0;
      r_bvalid    <= 1'b0;
      r_bresp     <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (r_aw_held && r_w_held) begin
            r_wsel <= w_wsel;
            if (w_whit) begin
              r_m_awvalid <= f_onehot(w_wsel);
              r_m_wvalid  <= f_onehot(w_wsel);
              r_wstate    <= W_FWD;
            end else begin
              r_wstate <= W_ERR;
            end
          end else begin
            if (r_awready && s_axi_lite_awvalid) begin
              r_awaddr  <= s_axi_lite_awaddr;
              r_aw_held <= 1'b1;
              r_awready <= 1'b0;
            end else if (!r_aw_held) begin
              r_awready <= 1'b1;
            end
            if (r_wready && s_axi_lite_wvalid) begin
              r_wdata  <= s_axi_lite_wdata;
              r_wstrb  <= s_axi_lite_wstrb;
              r_w_held <= 1'b1;
              r_wready <= 1'b0;
            end else if (!r_w_held) begin
              r_wready <= 1'b1;
            end
          end
        end
        W_FWD: begin
          r_m_awvalid <= w_awv_nxt;
          r_m_wvalid  <= w_wv_nxt;
          if (w_awv_nxt == '0 && w_wv_nxt == '0) begin
            r_m_bready <= f_onehot(r_wsel);
            r_wstate   <= W_WAITB;
          end
        end
        W_WAITB: begin
          if (|(r_m_bready & m_axi_lite_bvalid)) begin
            r_bresp    <= w_bresp_sel;
            r_m_bready <= '0;
            r_bvalid   <= 1'b1;
            r_wstate   <= W_RESP;
          end
        end
        W_ERR: begin
          r_bresp  <= 2'b11;
          r_bvalid <= 1'b1;
          r_wstate <= W_RESP;
        end
        W_RESP: begin
          if (s_axi_lite_bready) begin
            r_bvalid  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read path: same shape as the write path, with a single address channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate    <= R_IDLE;
      r_araddr    <= '0;
      r_ar_held   <= 1'b0;
      r_arready   <= 1'b0;
      r_rsel      <= '0;
      r_m_arvalid <= '0;
      r_m_rready  <= '0;
      r_rvalid    <= 1'b0;
      r_rresp     <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (r_ar_held) begin
            r_rsel <= w_rsel;
            if (w_rhit) begin
              r_m_arvalid <= f_onehot(w_rsel);
              r_rstate    <= R_FWD;
            end else begin
              r_rstate <= R_ERR;
            end
          end else if (r_arready && s_axi_lite_arvalid) begin
            r_araddr  <= s_axi_lite_araddr;
            r_ar_held <= 1'b1;
            r_arready <= 1'b0;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_FWD: begin
          r_m_arvalid <= w_arv_nxt;
          if (w_arv_nxt == '0) begin
            r_m_rready <= f_onehot(r_rsel);
            r_rstate   <= R_WAITR;
          end
        end
        R_WAITR: begin
          if (|(r_m_rready & m_axi_lite_rvalid)) begin
            r_rdata    <= w_rdata_sel;
            r_rresp    <= w_rresp_sel;
            r_m_rready <= '0;
            r_rvalid   <= 1'b1;
            r_rstate   <= R_RESP;
          end
        end
        R_ERR: begin
          r_rdata  <= '0;
          r_rresp  <= 2'b11;
          r_rvalid <= 1'b1;
          r_rstate <= R_RESP;
        end
        R_RESP: begin
          if (s_axi_lite_rready) begin
            r_rvalid  <= 1'b0;
            r_ar_held <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s_axi_lite_awready = r_awready;
  assign s_axi_lite_wready  = r_wready;
  assign s_axi_lite_bvalid  = r_bvalid;
  assign s_axi_lite_bresp   = r_bresp;
  assign s_axi_lite_arready = r_arready;
  assign s_axi_lite_rvalid  = r_rvalid;
  assign s_axi_lite_rresp   = r_rresp;
  assign s_axi_lite_rdata   = r_rdata;

  // Payloads are broadcast; only the valids and readies are steered.
  assign m_axi_lite_awaddr  = {N_SLAVES{r_awaddr}};
  assign m_axi_lite_wdata   = {N_SLAVES{r_wdata}};
  assign m_axi_lite_wstrb   = {N_SLAVES{r_wstrb}};
  assign m_axi_lite_araddr  = {N_SLAVES{r_araddr}};
  assign m_axi_lite_awvalid = r_m_awvalid;
  assign m_axi_lite_wvalid  = r_m_wvalid;
  assign m_axi_lite_bready  = r_m_bready;
  assign m_axi_lite_arvalid = r_m_arvalid;
  assign m_axi_lite_rready  = r_m_rready;

endmodule

// File: tb/tb_holy_axi_lite_demux.sv
// Bench for holy_axi_lite_demux: two behavioural slaves, a vector table of
// single transactions, and hand sequences for ordering, stalls, concurrency and reset.
module tb_holy_axi_lite_demux;
  localparam int N = 2;

  logic clk, rst_n;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp;
  logic [N*32-1:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [N*4-1:0]  m_wstrb;
  logic [N*2-1:0]  m_bresp, m_rresp;
  logic [N-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [N-1:0] m_arvalid, m_arready, m_rvalid, m_rready;

  holy_axi_lite_demux dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_lite_awaddr(s_awaddr), .s_axi_lite_awvalid(s_awvalid), .s_axi_lite_awready(s_awready),
    .s_axi_lite_wdata(s_wdata), .s_axi_lite_wstrb(s_wstrb), .s_axi_lite_wvalid(s_wvalid),
    .s_axi_lite_wready(s_wready), .s_axi_lite_bresp(s_bresp), .s_axi_lite_bvalid(s_bvalid),
    .s_axi_lite_bready(s_bready), .s_axi_lite_araddr(s_araddr), .s_axi_lite_arvalid(s_arvalid),
    .s_axi_lite_arready(s_arready), .s_axi_lite_rdata(s_rdata), .s_axi_lite_rresp(s_rresp),
    .s_axi_lite_rvalid(s_rvalid), .s_axi_lite_rready(s_rready),
    .m_axi_lite_awaddr(m_awaddr), .m_axi_lite_awvalid(m_awvalid), .m_axi_lite_awready(m_awready),
    .m_axi_lite_wdata(m_wdata), .m_axi_lite_wstrb(m_wstrb), .m_axi_lite_wvalid(m_wvalid),
    .m_axi_lite_wready(m_wready), .m_axi_lite_bresp(m_bresp), .m_axi_lite_bvalid(m_bvalid),
    .m_axi_lite_bready(m_bready), .m_axi_lite_araddr(m_araddr), .m_axi_lite_arvalid(m_arvalid),
    .m_axi_lite_arready(m_arready), .m_axi_lite_rdata(m_rdata), .m_axi_lite_rresp(m_rresp),
    .m_axi_lite_rvalid(m_rvalid), .m_axi_lite_rready(m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Slave configuration (written by the stimulus) and model state (written by the model).
  logic [1:0]  cfg_bresp[N], cfg_rresp[N];
  logic [31:0] cfg_rdata[N];
  int          cfg_rwait[N], cfg_aw_stall[N];
  logic        cfg_b_stall[N];

  logic        sl_aw_done[N], sl_w_done[N], sl_rpend[N], prev_stall[N];
  int          sl_aw_wait[N], sl_rcnt[N];
  logic [31:0] prev_addr[N], cap_awaddr[N], cap_wdata[N], cap_araddr[N];
  logic [3:0]  cap_wstrb[N];
  int awv_cyc[N], wv_cyc[N], arv_cyc[N], brdy_cyc[N], rrdy_cyc[N];
  int aw_hs[N], w_hs[N], ar_hs[N], b_hs[N];
  int stab_err;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_awready[i] = !sl_aw_done[i] && (sl_aw_wait[i] >= cfg_aw_stall[i]);
      m_wready[i]  = !sl_w_done[i];
      m_arready[i] = !sl_rpend[i] && !m_rvalid[i];
    end
  end

  initial begin
    stab_err = 0;
    for (int i = 0; i < N; i++) begin
      awv_cyc[i] = 0; wv_cyc[i] = 0; arv_cyc[i] = 0; brdy_cyc[i] = 0; rrdy_cyc[i] = 0;
      aw_hs[i] = 0; w_hs[i] = 0; ar_hs[i] = 0; b_hs[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin : slv
      logic awhs, whs, awnow, wnow;
      awhs = m_awvalid[i] && m_awready[i];
      whs  = m_wvalid[i] && m_wready[i];
      if (m_awvalid[i]) awv_cyc[i] <= awv_cyc[i] + 1;
      if (m_wvalid[i])  wv_cyc[i]  <= wv_cyc[i] + 1;
      if (m_arvalid[i]) arv_cyc[i] <= arv_cyc[i] + 1;
      if (m_bready[i])  brdy_cyc[i] <= brdy_cyc[i] + 1;
      if (m_rready[i])  rrdy_cyc[i] <= rrdy_cyc[i] + 1;
      if (prev_stall[i] && (!m_awvalid[i] || m_awaddr[i*32 +: 32] !== prev_addr[i]))
        stab_err <= stab_err + 1;
      prev_stall[i] <= m_awvalid[i] && !m_awready[i];
      prev_addr[i]  <= m_awaddr[i*32 +: 32];
      if (!rst_n) begin
        sl_aw_done[i] <= 1'b0; sl_w_done[i] <= 1'b0; sl_rpend[i] <= 1'b0;
        sl_aw_wait[i] <= 0; sl_rcnt[i] <= 0; m_bvalid[i] <= 1'b0; m_rvalid[i] <= 1'b0;
      end else begin
        if (awhs || !m_awvalid[i]) sl_aw_wait[i] <= 0;
        else sl_aw_wait[i] <= sl_aw_wait[i] + 1;
        if (awhs) begin aw_hs[i] <= aw_hs[i] + 1; cap_awaddr[i] <= m_awaddr[i*32 +: 32]; end
        if (whs) begin
          w_hs[i] <= w_hs[i] + 1; cap_wdata[i] <= m_wdata[i*32 +: 32]; cap_wstrb[i] <= m_wstrb[i*4 +: 4];
        end
        awnow = sl_aw_done[i] || awhs;
        wnow  = sl_w_done[i] || whs;
        if (awnow && wnow && !cfg_b_stall[i] && !m_bvalid[i]) begin
          m_bvalid[i] <= 1'b1; m_bresp[i*2 +: 2] <= cfg_bresp[i];
          sl_aw_done[i] <= 1'b0; sl_w_done[i] <= 1'b0;
        end else begin
          sl_aw_done[i] <= awnow; sl_w_done[i] <= wnow;
        end
        if (m_bvalid[i] && m_bready[i]) begin m_bvalid[i] <= 1'b0; b_hs[i] <= b_hs[i] + 1; end
        if (m_arvalid[i] && m_arready[i]) begin
          ar_hs[i] <= ar_hs[i] + 1; cap_araddr[i] <= m_araddr[i*32 +: 32];
          if (cfg_rwait[i] == 0) begin
            m_rvalid[i] <= 1'b1; m_rdata[i*32 +: 32] <= cfg_rdata[i]; m_rresp[i*2 +: 2] <= cfg_rresp[i];
          end else begin
            sl_rpend[i] <= 1'b1; sl_rcnt[i] <= cfg_rwait[i];
          end
        end
        if (sl_rpend[i]) begin
          sl_rcnt[i] <= sl_rcnt[i] - 1;
          if (sl_rcnt[i] == 1) begin
            m_rvalid[i] <= 1'b1; m_rdata[i*32 +: 32] <= cfg_rdata[i];
            m_rresp[i*2 +: 2] <= cfg_rresp[i]; sl_rpend[i] <= 1'b0;
          end
        end
        if (m_rvalid[i] && m_rready[i]) m_rvalid[i] <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int activity(input int i);
    return awv_cyc[i] + wv_cyc[i] + arv_cyc[i] + brdy_cyc[i] + rrdy_cyc[i];
  endfunction

  // Called and returns at 1 time unit after a rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int w_lead, input int b_hold, output logic [1:0] resp, output int lat);
    int c, bad;
    logic aw_ok, w_ok, awhs, whs;
    s_awaddr = a; s_wdata = d; s_wstrb = s; s_wvalid = 1'b1; s_awvalid = (w_lead == 0);
    aw_ok = 1'b0; w_ok = 1'b0; c = 0;
    while (!(aw_ok && w_ok) && c < 100) begin
      awhs = s_awvalid && s_awready;
      whs  = s_wvalid && s_wready;
      @(posedge clk); #1; c++;
      if (awhs) begin aw_ok = 1'b1; s_awvalid = 1'b0; end
      if (whs)  begin w_ok = 1'b1; s_wvalid = 1'b0; end
      if (!aw_ok && !s_awvalid && c >= w_lead) s_awvalid = 1'b1;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("wr_addr_data_accepted", {aw_ok, w_ok}, 2'b11);
    lat = 0;
    while (!s_bvalid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("wr_bvalid_seen", s_bvalid, 1'b1);
    resp = s_bresp;
    bad = 0;
    repeat (b_hold) begin
      @(posedge clk); #1;
      if (!s_bvalid || s_bresp !== resp || s_awready || s_wready) bad++;
    end
    if (b_hold > 0) chk("wr_bhold_stable", bad, 0);
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                    output int lat);
    int c;
    logic hs, done;
    s_araddr = a; s_arvalid = 1'b1; c = 0; done = 1'b0;
    while (!done && c < 100) begin
      hs = s_arvalid && s_arready;
      @(posedge clk); #1; c++;
      if (hs) done = 1'b1;
    end
    s_arvalid = 1'b0;
    chk("rd_addr_accepted", done, 1'b1);
    lat = 0;
    while (!s_rvalid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("rd_rvalid_seen", s_rvalid, 1'b1);
    d = s_rdata; resp = s_rresp;
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
  endtask

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  sresp;
    int          rwait;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_slave;
    int          exp_lat;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  initial begin
    logic [1:0]  resp, resp2;
    logic [31:0] rdat;
    int lat, lat2, p_aw[N], p_w[N], p_ar[N], p_act[N], p_b[N], p_stab, p_awv, c;

    vecs[0] = '{1'b1, 32'h1000_0004, 32'hCAFE_F00D, 4'hF, 2'b00, 0, 2'b00, 32'h0, 0, 3};
    vecs[1] = '{1'b0, 32'h2000_0010, 32'h1234_5678, 4'h0, 2'b00, 5, 2'b00, 32'h1234_5678, 1, 8};
    vecs[2] = '{1'b0, 32'h3000_0000, 32'hDEAD_BEEF, 4'h0, 2'b00, 0, 2'b11, 32'h0, -1, -1};
    vecs[3] = '{1'b1, 32'h4000_0000, 32'h0000_1111, 4'hF, 2'b00, 0, 2'b11, 32'h0, -1, -1};
    vecs[4] = '{1'b1, 32'h2000_0100, 32'h0BAD_0001, 4'h3, 2'b10, 0, 2'b10, 32'h0, 1, 3};
    vecs[5] = '{1'b0, 32'h1000_0008, 32'hA5A5_0001, 4'h0, 2'b01, 0, 2'b01, 32'hA5A5_0001, 0, 3};
    vecs[6] = '{1'b1, 32'h1FFF_FFFC, 32'h1122_3344, 4'h8, 2'b01, 0, 2'b01, 32'h0, 0, 3};
    vecs[7] = '{1'b0, 32'h2FFF_FFFC, 32'h0F0F_F0F0, 4'h0, 2'b00, 2, 2'b00, 32'h0F0F_F0F0, 1, 5};
    vecs[8] = '{1'b0, 32'h0FFF_FFFC, 32'h7777_7777, 4'h0, 2'b00, 0, 2'b11, 32'h0, -1, -1};
    vecs[9] = '{1'b1, 32'h0000_0000, 32'h5A5A_5A5A, 4'hF, 2'b00, 0, 2'b11, 32'h0, -1, -1};

    rst_n = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    for (int i = 0; i < N; i++) begin
      cfg_bresp[i] = 2'b00; cfg_rresp[i] = 2'b00; cfg_rdata[i] = '0;
      cfg_rwait[i] = 0; cfg_aw_stall[i] = 0; cfg_b_stall[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_up_readies", {s_awready, s_wready, s_arready}, 3'b000);
    chk("rst_up_valids", {s_bvalid, s_rvalid}, 2'b00);
    chk("rst_up_resp", {s_bresp, s_rresp, s_rdata}, 36'h0);
    chk("rst_m_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 10'h0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("idle_readies", {s_awready, s_wready, s_arready}, 3'b111);

    for (int v = 0; v < NV; v++) begin
      for (int i = 0; i < N; i++) begin
        cfg_bresp[i] = vecs[v].sresp; cfg_rresp[i] = vecs[v].sresp;
        cfg_rdata[i] = vecs[v].data;  cfg_rwait[i] = vecs[v].rwait;
        p_aw[i] = aw_hs[i]; p_w[i] = w_hs[i]; p_ar[i] = ar_hs[i]; p_act[i] = activity(i);
      end
      if (vecs[v].is_wr) begin
        wr(vecs[v].addr, vecs[v].data, vecs[v].strb, 0, 0, resp, lat);
      end else begin
        rd(vecs[v].addr, rdat, resp, lat);
        chk($sformatf("v%0d_rdata", v), rdat, vecs[v].exp_rdata);
      end
      chk($sformatf("v%0d_resp", v), resp, vecs[v].exp_resp);
      if (vecs[v].exp_lat >= 0) chk($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      for (int i = 0; i < N; i++) begin
        if (i == vecs[v].exp_slave) begin
          if (vecs[v].is_wr) begin
            chk($sformatf("v%0d_s%0d_aw_hs", v, i), aw_hs[i] - p_aw[i], 1);
            chk($sformatf("v%0d_s%0d_w_hs", v, i), w_hs[i] - p_w[i], 1);
            chk($sformatf("v%0d_s%0d_awaddr", v, i), cap_awaddr[i], vecs[v].addr);
            chk($sformatf("v%0d_s%0d_wdata", v, i), cap_wdata[i], vecs[v].data);
            chk($sformatf("v%0d_s%0d_wstrb", v, i), cap_wstrb[i], vecs[v].strb);
          end else begin
            chk($sformatf("v%0d_s%0d_ar_hs", v, i), ar_hs[i] - p_ar[i], 1);
            chk($sformatf("v%0d_s%0d_araddr", v, i), cap_araddr[i], vecs[v].addr);
          end
        end else begin
          chk($sformatf("v%0d_s%0d_idle", v, i), activity(i) - p_act[i], 0);
        end
      end
    end

    // W ahead of AW by 4 cycles, then slave1 holds awready low for 3 cycles.
    cfg_aw_stall[1] = 3; cfg_bresp[1] = 2'b00;
    p_aw[1] = aw_hs[1]; p_w[1] = w_hs[1]; p_b[1] = b_hs[1]; p_stab = stab_err; p_awv = awv_cyc[1];
    p_act[0] = activity(0);
    wr(32'h2000_0200, 32'h0000_BEEF, 4'hF, 4, 0, resp, lat);
    chk("wfirst_resp", resp, 2'b00);
    chk("wfirst_aw_hs", aw_hs[1] - p_aw[1], 1);
    chk("wfirst_w_hs", w_hs[1] - p_w[1], 1);
    chk("wfirst_b_hs", b_hs[1] - p_b[1], 1);
    chk("wfirst_awvalid_cycles", awv_cyc[1] - p_awv, 4);
    chk("wfirst_aw_stable", stab_err - p_stab, 0);
    chk("wfirst_wdata", cap_wdata[1], 32'h0000_BEEF);
    chk("wfirst_s0_idle", activity(0) - p_act[0], 0);
    cfg_aw_stall[1] = 0;

    // Read to slave0 while a write response from slave1 is held off by bready.
    cfg_rwait[0] = 1; cfg_rdata[0] = 32'h5555_AAAA; cfg_rresp[0] = 2'b00; cfg_bresp[1] = 2'b00;
    fork
      begin
        rd(32'h1000_0020, rdat, resp2, lat2);
      end
      begin
        wr(32'h2000_0040, 32'h0000_0042, 4'hF, 0, 10, resp, lat);
      end
    join
    chk("conc_rd_data", rdat, 32'h5555_AAAA);
    chk("conc_rd_resp", resp2, 2'b00);
    chk("conc_rd_latency", lat2, 4);
    chk("conc_wr_resp", resp, 2'b00);
    chk("conc_wr_latency", lat, 3);

    // Reset while the write path waits on slave0's response.
    cfg_b_stall[0] = 1'b1;
    s_awaddr = 32'h1000_0000; s_wdata = 32'h0000_00AA; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    c = 0;
    while (m_bready[0] !== 1'b1 && c < 50) begin
      @(posedge clk); #1; c++;
      if (!s_awready) s_awvalid = 1'b0;
      if (!s_wready)  s_wvalid = 1'b0;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("rstmid_reached_waitb", m_bready[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_m_signals", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 10'h0);
    chk("rstmid_s_signals", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, 5'h0);
    chk("rstmid_resp", {s_bresp, s_rresp}, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; cfg_b_stall[0] = 1'b0; cfg_bresp[0] = 2'b00;
    repeat (2) begin @(posedge clk); #1; end
    chk("rstmid_no_stale_bvalid", s_bvalid, 1'b0);
    p_b[0] = b_hs[0];
    wr(32'h1000_0000, 32'h0000_0077, 4'hF, 0, 0, resp, lat);
    chk("rstmid_after_resp", resp, 2'b00);
    chk("rstmid_after_latency", lat, 3);
    chk("rstmid_after_b_hs", b_hs[0] - p_b[0], 1);
    chk("rstmid_after_wdata", cap_wdata[0], 32'h0000_0077);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/holy_axi_lite_demux.md
Name: holy_axi_lite_demux

Overview:
Parametrised 1-to-N AXI-Lite router between the core's AXI-Lite master port and N peripheral slaves (UART, PLIC, CLINT, GPIO, ...). It decodes each address against a per-slave base/mask map and forwards the transaction to the matching slave. Unmapped addresses complete locally with DECERR. One outstanding write and one outstanding read at a time; the write and read paths are independent.

Parameters:
N_SLAVES, 2, number of downstream slaves (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width (32 or 64); STRB_W = DATA_W/8
BASE_ADDRS, {32'h2000_0000, 32'h1000_0000}, flattened N_SLAVES*ADDR_W; slave i occupies [i*ADDR_W +: ADDR_W]
ADDR_MASKS, {32'hF000_0000, 32'hF000_0000}, flattened; slave i hits when (addr & mask_i) == (base_i & mask_i)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axi_lite_aw{addr,valid,ready}  in/in/out  ADDR_W/1/1  upstream write address
s_axi_lite_w{data,strb,valid,ready}  in/in/in/out  DATA_W/STRB_W/1/1  upstream write data
s_axi_lite_b{resp,valid,ready}  out/out/in  2/1/1  upstream write response
s_axi_lite_ar{addr,valid,ready}  in/in/out  ADDR_W/1/1  upstream read address
s_axi_lite_r{data,resp,valid,ready}  out/out/out/in  DATA_W/2/1/1  upstream read data
m_axi_lite_awaddr  out  N_SLAVES*ADDR_W  per-slave AW address; m_axi_lite_aw{valid,ready}  out/in  N_SLAVES each
m_axi_lite_wdata/wstrb  out  N_SLAVES*DATA_W / N_SLAVES*STRB_W; m_axi_lite_w{valid,ready}  out/in  N_SLAVES each
m_axi_lite_bresp  in  N_SLAVES*2; m_axi_lite_b{valid,ready}  in/out  N_SLAVES each
m_axi_lite_araddr  out  N_SLAVES*ADDR_W; m_axi_lite_ar{valid,ready}  out/in  N_SLAVES each
m_axi_lite_rdata/rresp  in  N_SLAVES*DATA_W / N_SLAVES*2; m_axi_lite_r{valid,ready}  in/out  N_SLAVES each

Behaviour:
- Reset (async, rst_n=0): both FSMs to IDLE; every valid/ready output 0; s_bresp, s_rresp, s_rdata 0; latched addr/data/sel 0. Takes effect immediately, including mid-transaction; in-flight transfers are abandoned without a response.
- Decode: the lowest index i that hits wins. No hit = decode miss. Decode is combinational on the captured address and is registered as sel_q plus miss_q.
- Write FSM states: W_IDLE, W_FWD, W_WAITB, W_RESP, W_ERR.
- W_IDLE: s_awready=1 and s_wready=1. AW and W are captured independently; either may arrive first. Once both are held, go to W_FWD, or to W_ERR on a miss. Capture costs one cycle: the slave sees awvalid no earlier than the cycle after the last of AW/W is captured.
- W_FWD: drive m_awvalid[sel_q] and m_wvalid[sel_q] with the latched values. Each valid drops independently on its own ready. When both have handshaked, go to W_WAITB. Address, data and strobe are broadcast to all slaves; only valids are one-hot.
- W_WAITB: m_bready[sel_q]=1. On m_bvalid[sel_q], capture bresp and go to W_RESP.
- W_ERR: bresp=2'b11; go to W_RESP next cycle. No slave signal toggles.
- W_RESP: s_bvalid=1 until s_bready, then W_IDLE. s_bresp is held stable while s_bvalid=1.
- Read FSM states: R_IDLE, R_FWD, R_WAITR, R_RESP, R_ERR. Mirrors the write FSM.
  - R_IDLE: s_arready=1.
  - R_FWD: m_arvalid[sel_q] until arready.
  - R_WAITR: m_rready[sel_q]=1; capture rdata and rresp.
  - R_ERR: rdata=0, rresp=2'b11.
  - R_RESP: s_rvalid=1 until s_rready.
- Minimum round-trip latency with a zero-wait slave, from upstream handshake to upstream response valid: 3 cycles for both read and write.
- Simultaneous read and write to the same or different slaves proceed concurrently with no mutual blocking.
- Responses from non-selected slaves are ignored; their bready/rready stay 0.
- Back-pressure: an upstream response held by s_bready=0 or s_rready=0 blocks new transactions on that path only.

Test Plan:
- Write 0x1000_0004 data 0xCAFE_F00D strb 4'hF, zero-wait slaves → slave0 receives awaddr 0x1000_0004 and wdata 0xCAFE_F00D; slave1 valids stay 0; s_bresp=2'b00, s_bvalid asserted 3 cycles after the AW/W handshake.
- Read 0x2000_0010 with slave1 returning 0x1234_5678 after 5 wait cycles → s_rdata=0x1234_5678, s_rresp=2'b00; slave0 arvalid never asserts.
- Read 0x3000_0000 and write 0x4000_0000 (unmapped) → s_rresp=2'b11 with s_rdata=0, s_bresp=2'b11; no m_* valid asserts.
- W presented 4 cycles before AW, then slave1 awready held low for 3 cycles while wready=1 → single W handshake, awvalid held stable, single bresp returned.
- Concurrent read to slave0 and write to slave1, with s_bready low for 10 cycles → read completes unaffected; bvalid and bresp stay stable until s_bready rises.
- rst_n pulsed low during W_WAITB → all valids/readies 0 in the same cycle; after release, a new write to 0x1000_0000 completes normally with OKAY.
